// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - slew-limited signed duty sequencer with reversal coast and fault latch
// Define PWM_SEQ_WATCHDOG_EN to add the no-new-target watchdog stop.
module pwm_duty_sequencer #(
  parameter int MAX_COUNT    = 10000,
  parameter int STEP         = 100,
  parameter int DEAD_PERIODS = 4,
  parameter int WDOG_PERIODS = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tgt_valid,
  input  logic signed [31:0] tgt_duty,
  output logic               tgt_ready,
  input  logic               fault,
  input  logic               fault_clr,
  output logic signed [31:0] duty_out,
  output logic               at_target,
  output logic               fault_active,
  output logic               wdog_expired
);

  localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic signed [32:0] STEP_W = 33'(STEP);
  localparam logic signed [31:0] STEP_N = 32'(STEP);
  localparam logic signed [31:0] MAX_N  = 32'(MAX_COUNT);

  typedef enum logic [2:0] {S_IDLE, S_RAMP, S_HOLD, S_COAST, S_FAULT} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic               tick;
  logic [DW-1:0]      coast_cnt;
  logic               coast_done;
  logic signed [31:0] target;
  logic signed [31:0] tgt_clip;
  logic signed [31:0] duty_step;
  logic signed [32:0] duty_w;
  logic signed [32:0] target_w;
  logic signed [32:0] diff;
  logic               rev;
  logic               accept;
  logic               wdog_fire;

  assign tick       = (cnt == CW'(MAX_COUNT - 1));
  assign coast_done = (coast_cnt == DW'(DEAD_PERIODS - 1));
  assign accept     = tgt_valid && tgt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  always_comb begin
    tgt_clip = tgt_duty;
    if (tgt_duty > MAX_N)       tgt_clip = MAX_N;
    else if (tgt_duty < -MAX_N) tgt_clip = -MAX_N;
  end

  // Opposite nonzero signs always pass through zero first, never a direct flip.
  always_comb begin
    duty_w    = {duty_out[31], duty_out};
    target_w  = {target[31], target};
    diff      = target_w - duty_w;
    rev       = (duty_out != '0) && (target != '0) && (duty_out[31] != target[31]);
    duty_step = duty_out;
    if (rev) begin
      if ((duty_w <= STEP_W) && (duty_w >= -STEP_W)) duty_step = '0;
      else if (duty_out[31])                         duty_step = duty_out + STEP_N;
      else                                           duty_step = duty_out - STEP_N;
    end else if ((diff <= STEP_W) && (diff >= -STEP_W)) begin
      duty_step = target;
    end else if (diff[32]) begin
      duty_step = duty_out - STEP_N;
    end else begin
      duty_step = duty_out + STEP_N;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fault) begin
      state_nxt = S_FAULT;
    end else begin
      case (state)
        S_FAULT: if (fault_clr) state_nxt = S_IDLE;
        S_COAST: if (tick && coast_done) state_nxt = (target == '0) ? S_IDLE : S_RAMP;
        default: begin
          if (tick) begin
            if (rev && (duty_step == '0))  state_nxt = S_COAST;
            else if (duty_step == target)  state_nxt = (target == '0) ? S_IDLE : S_HOLD;
            else                           state_nxt = S_RAMP;
          end else if (target != duty_out) begin
            state_nxt = S_RAMP;
          end
        end
      endcase
    end
  end

  always_comb begin
    tgt_ready    = (state != S_FAULT) && !fault;
    fault_active = (state == S_FAULT);
    at_target    = (duty_out == target) && ((state == S_HOLD) || (state == S_IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    coast_cnt <= '0;
    else if (state != S_COAST)     coast_cnt <= '0;
    else if (tick && !coast_done)  coast_cnt <= coast_cnt + DW'(1);
  end

  // Fault entry is the only duty change not aligned to the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_out <= '0;
      target   <= '0;
    end else if (fault || (state == S_FAULT)) begin
      duty_out <= '0;
      target   <= '0;
    end else begin
      if (tick && (state != S_COAST)) duty_out <= duty_step;
      if (accept)         target <= tgt_clip;
      else if (wdog_fire) target <= '0;
    end
  end

`ifdef PWM_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_PERIODS + 1);
  logic [WW-1:0] wdog_cnt;

  assign wdog_fire = tick && !wdog_expired && (wdog_cnt == WW'(WDOG_PERIODS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt     <= '0;
      wdog_expired <= 1'b0;
    end else if (accept) begin
      wdog_cnt     <= '0;
      wdog_expired <= 1'b0;
    end else if (wdog_fire) begin
      wdog_expired <= 1'b1;
    end else if (tick && !wdog_expired) begin
      wdog_cnt <= wdog_cnt + WW'(1);
    end
  end
`else
  assign wdog_fire    = 1'b0;
  assign wdog_expired = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb/tb_pwm_duty_sequencer.sv - directed and randomized checks of pwm_duty_sequencer against a period-level model
module tb_pwm_duty_sequencer;
  localparam int MAXC  = 100;
  localparam int STEPV = 10;
  localparam int DEAD  = 2;
  localparam int WDOG  = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tgt_valid = 1'b0;
  logic signed [31:0] tgt_duty = '0;
  logic               fault = 1'b0;
  logic               fault_clr = 1'b0;
  logic               tgt_ready;
  logic signed [31:0] duty_out;
  logic               at_target;
  logic               fault_active;
  logic               wdog_expired;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt, m_duty, m_target, m_coast, m_wd;
  bit m_fault, m_wexp, m_tick;

  int seq2[4] = '{10, 20, 30, 35};
  int seq3[7] = '{20, 10, 0, 0, 0, -10, -20};
  int seq6[6] = '{10, 20, 20, 20, 10, 0};
  int wex6[6] = '{0, 0, 0, 1, 1, 1};

  always #5 clk = ~clk;

  pwm_duty_sequencer #(
    .MAX_COUNT(MAXC), .STEP(STEPV), .DEAD_PERIODS(DEAD), .WDOG_PERIODS(WDOG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_duty(tgt_duty),
    .tgt_ready(tgt_ready), .fault(fault), .fault_clr(fault_clr),
    .duty_out(duty_out), .at_target(at_target), .fault_active(fault_active),
    .wdog_expired(wdog_expired)
  );

  task automatic expect_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clip(input int v);
    if (v > MAXC)  return MAXC;
    if (v < -MAXC) return -MAXC;
    return v;
  endfunction

  // One clk of the reference: duty moves only at period ends, by at most STEPV,
  // and passes through DEAD idle periods at zero when the direction flips.
  task automatic model_clock();
    bit acc;
    int d;
    m_tick = (m_cnt == MAXC - 1);
    m_cnt  = m_tick ? 0 : m_cnt + 1;
    acc    = tgt_valid && !m_fault && !fault;
    if (fault) begin
      m_fault = 1; m_duty = 0; m_target = 0; m_coast = 0;
    end else if (m_fault) begin
      if (fault_clr) m_fault = 0;
    end else begin
      if (m_tick) begin
        if (m_coast > 0) begin
          m_coast--;
        end else begin
          d = m_duty;
          if (longint'(d) * m_target < 0) begin
            if (d > 0) m_duty = (d - STEPV < 0) ? 0 : d - STEPV;
            else       m_duty = (d + STEPV > 0) ? 0 : d + STEPV;
            if (m_duty == 0) m_coast = DEAD;
          end else if (m_target - d <= STEPV && d - m_target <= STEPV) begin
            m_duty = m_target;
          end else begin
            m_duty = d + ((m_target > d) ? STEPV : -STEPV);
          end
        end
      end
      if (acc) m_target = clip(tgt_duty);
    end
`ifdef PWM_SEQ_WATCHDOG_EN
    if (acc) begin
      m_wd = 0; m_wexp = 0;
    end else if (m_tick && !m_wexp) begin
      m_wd++;
      if (m_wd == WDOG) begin
        m_wexp = 1; m_target = 0;
      end
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    expect_eq("duty", duty_out, m_duty);
    expect_eq("ready", tgt_ready, !m_fault && !fault);
    expect_eq("fault_active", fault_active, m_fault);
    expect_eq("wdog", wdog_expired, m_wexp);
  endtask

  task automatic to_tick();
    do step(); while (!m_tick);
  endtask

  task automatic send(input int v);
    tgt_valid = 1'b1;
    tgt_duty  = v;
    step();
    tgt_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int prev;
    int r;
    m_cnt = 0; m_duty = 0; m_target = 0; m_coast = 0; m_wd = 0;
    m_fault = 0; m_wexp = 0; m_tick = 0;
    repeat (3) @(negedge clk);
    expect_eq("rst_duty", duty_out, 0);
    expect_eq("rst_ready", tgt_ready, 1);
    expect_eq("rst_at_target", at_target, 1);
    expect_eq("rst_fault_active", fault_active, 0);
    expect_eq("rst_wdog", wdog_expired, 0);
    rst_n = 1'b1;
    step();
    expect_eq("idle_at_target", at_target, 1);

`ifdef PWM_SEQ_WATCHDOG_EN
    send(20);
    for (int i = 0; i < 6; i++) begin
      to_tick();
      expect_eq("t6_duty", duty_out, seq6[i]);
      expect_eq("t6_wdog", wdog_expired, wex6[i]);
    end
    send(5);
    expect_eq("t6_wdog_clear", wdog_expired, 0);
`else
    send(35);
    for (int i = 0; i < 4; i++) begin
      to_tick();
      expect_eq("t2_duty", duty_out, seq2[i]);
      expect_eq("t2_at_target", at_target, (seq2[i] == 35) ? 1 : 0);
    end

    send(30);
    to_tick();
    expect_eq("t3_hold", duty_out, 30);
    send(-20);
    prev = 30;
    for (int i = 0; i < 7; i++) begin
      to_tick();
      expect_eq("t3_duty", duty_out, seq3[i]);
      expect_eq("t3_no_flip", ((prev > 0 && duty_out < 0) || (prev < 0 && duty_out > 0)) ? 1 : 0, 0);
      prev = duty_out;
    end
    expect_eq("t3_at_target", at_target, 1);

    send(0);
    repeat (2) to_tick();
    expect_eq("t4_zero", duty_out, 0);
    send(500);
    for (int i = 1; i <= 10; i++) begin
      to_tick();
      expect_eq("t4_pos", duty_out, 10 * i);
    end
    expect_eq("t4_pos_at_target", at_target, 1);
    send(-500);
    repeat (10) to_tick();
    expect_eq("t4_rev_zero", duty_out, 0);
    repeat (12) to_tick();
    expect_eq("t4_neg", duty_out, -100);
    expect_eq("t4_neg_at_target", at_target, 1);

    send(0);
    repeat (10) to_tick();
    send(60);
    repeat (4) to_tick();
    expect_eq("t5_mid", duty_out, 40);
    fault = 1'b1;
    step();
    expect_eq("t5_fault_duty", duty_out, 0);
    expect_eq("t5_fault_ready", tgt_ready, 0);
    expect_eq("t5_fault_active", fault_active, 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    expect_eq("t5_clr_ignored", fault_active, 1);
    fault = 1'b0;
    step();
    expect_eq("t5_latched", fault_active, 1);
    expect_eq("t5_latched_ready", tgt_ready, 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    expect_eq("t5_exit", fault_active, 0);
    expect_eq("t5_exit_ready", tgt_ready, 1);
    expect_eq("t5_exit_at_target", at_target, 1);
    repeat (2) to_tick();
    expect_eq("t5_no_restore", duty_out, 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      tgt_valid = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 9);
      if (r == 0) tgt_duty = $urandom;
      else        tgt_duty = int'($urandom_range(0, 300)) - 150;
      if (!fault && $urandom_range(0, 299) == 0) fault = 1'b1;
      else if (fault && $urandom_range(0, 3) == 0) fault = 1'b0;
      fault_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
